// File: rtl/prod_scale.sv
// prod_scale: rounds a 64-bit product, drops FRAC_BITS fraction bits and saturates to OUT_W bits.
// Two-stage valid/ready pipeline. Define PROD_SCALE_ACC_EN to enable the accumulate mode (adds i_acc_clr).
module prod_scale #(
   parameter int FRAC_BITS = 16,
   parameter int OUT_W     = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [63:0]      i_product,
`ifdef PROD_SCALE_ACC_EN
   input  logic             i_acc_clr,
`endif
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [OUT_W-1:0] o_result,
   output logic             o_sat,
   output logic [15:0]      o_sat_count
);
   logic             r_s1_valid, r_s2_valid, r_sat;
   logic [64:0]      r_s1_sum;
   logic [OUT_W-1:0] r_result;
   logic [15:0]      r_sat_count;
   logic             w_adv1, w_adv2, w_q_ovf, w_new_sat;
   logic [64:0]      w_q;
   logic [OUT_W-1:0] w_scaled, w_new;

   assign w_adv2     = !r_s2_valid || i_out_ready;
   assign w_adv1     = !r_s1_valid || w_adv2;
   assign o_in_ready = w_adv1;
   assign w_q        = r_s1_sum >> FRAC_BITS;
   assign w_q_ovf    = |w_q[64:OUT_W];
   assign w_scaled   = w_q_ovf ? {OUT_W{1'b1}} : w_q[OUT_W-1:0];

`ifdef PROD_SCALE_ACC_EN
   logic             r_s1_clr;
   logic [OUT_W:0]   w_sum;
   // r_result doubles as the accumulator: it is only rewritten when S2 loads
   assign w_sum     = {1'b0, r_result} + {1'b0, w_scaled};
   assign w_new     = r_s1_clr ? w_scaled : (w_sum[OUT_W] ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0]);
   assign w_new_sat = w_q_ovf || (!r_s1_clr && w_sum[OUT_W]);

   // carry the clear flag alongside the S1 sum
   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_s1_clr <= 1'b0;
      else if (w_adv1 && i_in_valid)
         r_s1_clr <= i_acc_clr;
   end
`else
   assign w_new     = w_scaled;
   assign w_new_sat = w_q_ovf;
`endif

   // S1: widen to 65 bits and add half an LSB so the carry from rounding is kept
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
      end else if (w_adv1) begin
         r_s1_valid <= i_in_valid;
         if (i_in_valid)
            r_s1_sum <= {1'b0, i_product} + (65'd1 << (FRAC_BITS - 1));
      end
   end

   // S2: scaled and clamped value; held stable while the consumer stalls
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_sat      <= 1'b0;
      end else if (w_adv2) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result <= w_new;
            r_sat    <= w_new_sat;
         end
      end
   end

   // count delivered clamped results, sticking at the top value
   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_sat_count <= '0;
      else if (r_s2_valid && i_out_ready && r_sat && r_sat_count != 16'hFFFF)
         r_sat_count <= r_sat_count + 16'd1;
   end

   assign o_out_valid = r_s2_valid;
   assign o_result    = r_result;
   assign o_sat       = r_sat;
   assign o_sat_count = r_sat_count;
endmodule

// File: tb/tb_prod_scale.sv
// tb_prod_scale: directed vector bench for prod_scale (FRAC_BITS=16, OUT_W=32)
module tb_prod_scale;
   typedef struct {
      logic [63:0] product;
      logic [31:0] result;
      logic        sat;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, sat;
   logic [63:0] product;
   logic [31:0] result;
   logic [15:0] sat_count;
`ifdef PROD_SCALE_ACC_EN
   logic        acc_clr;
`endif
   int          n_vec = 0;
   int          n_bad = 0;
   vec_t        tv[10];

   always #5 clk = ~clk;

   prod_scale #(.FRAC_BITS(16), .OUT_W(32)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_product   (product),
`ifdef PROD_SCALE_ACC_EN
      .i_acc_clr   (acc_clr),
`endif
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_result    (result),
      .o_sat       (sat),
      .o_sat_count (sat_count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // one product with the output side open: in_ready now, idle next cycle, result the cycle after
   task automatic send(input logic [63:0] p, input logic [31:0] er, input logic es);
      @(negedge clk);
      in_valid  = 1'b1;
      product   = p;
      out_ready = 1'b1;
      #1 chk("in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("latency1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk("latency2_valid", 64'(out_valid), 64'd1);
      chk("result", 64'(result), 64'(er));
      chk("sat", 64'(sat), 64'(es));
   endtask

   initial begin
      logic [31:0] held;
      bit          stalled, fell;
      int          sent, recv, cyc;
      tv[0] = '{64'h0000_0003_0000_8000, 32'h0003_0001, 1'b0};
      tv[1] = '{64'h0000_0000_0001_7FFF, 32'h0000_0001, 1'b0};
      tv[2] = '{64'h0000_FFFF_FFFF_7FFF, 32'hFFFF_FFFF, 1'b0};
      tv[3] = '{64'h0000_FFFF_FFFF_8000, 32'hFFFF_FFFF, 1'b1};
      tv[4] = '{64'h0001_0000_0000_0000, 32'hFFFF_FFFF, 1'b1};
      tv[5] = '{64'h0000_0000_0000_0000, 32'h0000_0000, 1'b0};
      tv[6] = '{64'h0000_0000_0000_8000, 32'h0000_0001, 1'b0};
      tv[7] = '{64'h0000_0000_0000_7FFF, 32'h0000_0000, 1'b0};
      tv[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
      tv[9] = '{64'h0000_1234_5678_9ABC, 32'h1234_5679, 1'b0};
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      product   = '0;
`ifdef PROD_SCALE_ACC_EN
      acc_clr   = 1'b1;
`endif
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_sat", 64'(sat), 64'd0);
      chk("rst_sat_count", 64'(sat_count), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) send(tv[i].product, tv[i].result, tv[i].sat);
      @(negedge clk);
      #1 chk("sat_count_after_table", 64'(sat_count), 64'd3);

      // backpressure: six back-to-back products, consumer stalled for the first five cycles
      stalled = 0; fell = 0; sent = 0; recv = 0; cyc = 0; held = '0;
      while (recv < 6 && cyc < 40) begin
         @(negedge clk);
         out_ready = (cyc >= 5);
         in_valid  = (sent < 6);
         product   = 64'(sent + 1) << 16;
         #1;
         if (stalled && out_valid) chk("stall_stable", 64'(result), 64'(held));
         if (!in_ready && !fell) begin
            fell = 1;
            chk("in_ready_fall_after", 64'(sent), 64'd2);
         end
         if (out_valid && out_ready) begin
            recv++;
            chk("bp_order", 64'(result), 64'(recv));
         end
         stalled = out_valid && !out_ready;
         held    = result;
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      chk("bp_all_received", 64'(recv), 64'd6);
      chk("bp_saw_in_ready_low", 64'(fell), 64'd1);

      // reset with both stages holding saturating values while the consumer is ready
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      product   = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("pre_rst_full_valid", 64'(out_valid), 64'd1);
      chk("pre_rst_full_in_ready", 64'(in_ready), 64'd0);
      reset     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_sat_count", 64'(sat_count), 64'd0);
      chk("mid_rst_result", 64'(result), 64'd0);
      @(negedge clk);
      #1 chk("mid_rst_s1_flushed", 64'(out_valid), 64'd0);
      send(64'h0000_0003_0000_8000, 32'h0003_0001, 1'b0);

`ifdef PROD_SCALE_ACC_EN
      // accumulate: 1, 2, 3 then clamp on overflow of the accumulator
      acc_clr = 1'b1;
      send(64'h0000_0000_0001_0000, 32'd1, 1'b0);
      acc_clr = 1'b0;
      send(64'h0000_0000_0001_0000, 32'd2, 1'b0);
      send(64'h0000_0000_0001_0000, 32'd3, 1'b0);
      send(64'h0000_FFFF_FFFF_0000, 32'hFFFF_FFFF, 1'b1);
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
